// File: rtl/interrupt_sequencer_if.sv
// CPU-side handshake of the interrupt sequencer: acknowledge pulses, EOI commands,
// the interrupt request line and the vector byte returned during acknowledge.
interface interrupt_sequencer_if;
   logic       inta_n;
   logic       eoi_valid;
   logic       eoi_specific;
   logic [2:0] eoi_level;
   logic       int_out;
   logic [7:0] data_out;
   logic       data_out_valid;

   modport master (
      output inta_n, eoi_valid, eoi_specific, eoi_level,
      input  int_out, data_out, data_out_valid
   );

   modport slave (
      input  inta_n, eoi_valid, eoi_specific, eoi_level,
      output int_out, data_out, data_out_valid
   );
endinterface

// File: rtl/interrupt_sequencer.sv
// 8-line nested interrupt sequencer with fixed/rotating priority and a two-pulse
// acknowledge cycle. Define AUTO_EOI_EN to add the auto_eoi input (automatic EOI).
module interrupt_sequencer (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           ir,
   input  logic                 level_triggered,
   input  logic [7:0]           interrupt_mask,
   input  logic                 rotate_mode,
   input  logic [4:0]           vector_base,
`ifdef AUTO_EOI_EN
   input  logic                 auto_eoi,
`endif
   interrupt_sequencer_if.slave cpu,
   output logic [7:0]           interrupt_request_register,
   output logic [7:0]           in_service_register
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PEND = 2'd1;
   localparam logic [1:0] ACK1 = 2'd2;
   localparam logic [1:0] ACK2 = 2'd3;

   logic [1:0] state_q, state_d;
   logic [7:0] irr_q, irr_d;
   logic [7:0] isr_q, isr_d;
   logic [7:0] ir_prev_q;
   logic [2:0] lp_q, lp_d;
   logic [2:0] level_q, level_d;
   logic       spurious_q, spurious_d;
   logic       inta_q;
   logic       int_out_q, int_out_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;

   // Returns {found, level} of the highest-priority set bit; priority starts at lp+1.
   function automatic logic [3:0] find_top(input logic [7:0] bits, input logic [2:0] lp);
      logic [3:0] r;
      logic [2:0] lvl;
      r = 4'd0;
      for (int k = 7; k >= 0; k--) begin
         lvl = lp + 3'd1 + 3'(k);
         if (bits[lvl]) r = {1'b1, lvl};
      end
      return r;
   endfunction

   function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lp);
      return lvl - lp - 3'd1;
   endfunction

   logic       inta_fall, inta_rise, auto_eoi_on;
   logic [2:0] eff_ptr, ptr_e, eoi_tgt;
   logic [3:0] isr_top, top_e, cand;
   logic [7:0] isr_e, irr_clr;
   logic       eoi_hit, eligible;

`ifdef AUTO_EOI_EN
   assign auto_eoi_on = auto_eoi;
`else
   assign auto_eoi_on = 1'b0;
`endif

   assign inta_fall = ~cpu.inta_n & inta_q;
   assign inta_rise = cpu.inta_n & ~inta_q;
   assign eff_ptr   = rotate_mode ? lp_q : 3'd7;
   assign isr_top   = find_top(isr_q, eff_ptr);
   assign eoi_tgt   = cpu.eoi_specific ? cpu.eoi_level : isr_top[2:0];
   assign eoi_hit   = cpu.eoi_valid & (cpu.eoi_specific ? isr_q[cpu.eoi_level] : isr_top[3]);

   // EOI is applied before eligibility so a coincident acknowledge sees the cleared ISR.
   always_comb begin
      isr_e = isr_q;
      ptr_e = eff_ptr;
      if (eoi_hit) begin
         isr_e = isr_q & ~(8'b1 << eoi_tgt);
         if (rotate_mode) ptr_e = eoi_tgt;
      end
   end

   assign cand     = find_top(irr_q & ~interrupt_mask, ptr_e);
   assign top_e    = find_top(isr_e, ptr_e);
   assign eligible = cand[3] & (~top_e[3] | (prio_rank(cand[2:0], ptr_e) < prio_rank(top_e[2:0], ptr_e)));

   always_comb begin
      state_d    = state_q;
      isr_d      = isr_e;
      lp_d       = rotate_mode ? ptr_e : 3'd7;
      level_d    = level_q;
      spurious_d = spurious_q;
      data_d     = data_q;
      valid_d    = valid_q;
      irr_clr    = 8'd0;
      case (state_q)
         IDLE, PEND: begin
            if (inta_fall) begin
               state_d = ACK1;
               if (eligible) begin
                  level_d    = cand[2:0];
                  spurious_d = 1'b0;
                  isr_d      = isr_e | (8'b1 << cand[2:0]);
                  irr_clr    = 8'b1 << cand[2:0];
               end else begin
                  level_d    = 3'd7;
                  spurious_d = 1'b1;
               end
            end else begin
               state_d = eligible ? PEND : IDLE;
            end
         end
         ACK1: begin
            if (inta_fall) begin
               state_d = ACK2;
               data_d  = {vector_base, level_q};
               valid_d = 1'b1;
            end
         end
         default: begin
            if (inta_rise) begin
               state_d = IDLE;
               data_d  = 8'd0;
               valid_d = 1'b0;
               if (auto_eoi_on && !spurious_q) begin
                  isr_d = isr_d & ~(8'b1 << level_q);
                  if (rotate_mode) lp_d = level_q;
               end
            end
         end
      endcase
      irr_d     = level_triggered ? ir : ((irr_q & ~irr_clr) | (ir & ~ir_prev_q));
      int_out_d = (state_d == PEND);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         irr_q      <= 8'd0;
         isr_q      <= 8'd0;
         ir_prev_q  <= 8'd0;
         lp_q       <= 3'd7;
         level_q    <= 3'd0;
         spurious_q <= 1'b0;
         inta_q     <= 1'b1;
         int_out_q  <= 1'b0;
         data_q     <= 8'd0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         irr_q      <= irr_d;
         isr_q      <= isr_d;
         ir_prev_q  <= ir;
         lp_q       <= lp_d;
         level_q    <= level_d;
         spurious_q <= spurious_d;
         inta_q     <= cpu.inta_n;
         int_out_q  <= int_out_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
      end
   end

   assign cpu.int_out                = int_out_q;
   assign cpu.data_out               = data_q;
   assign cpu.data_out_valid         = valid_q;
   assign interrupt_request_register = irr_q;
   assign in_service_register        = isr_q;
endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 The block SHALL have no parameters; all configuration SHALL come from input ports and one macro (REQ-030).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset on the ports below.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ir  input  8  interrupt request lines, already synchronous to clk.
REQ-006 level_triggered  input  1  1 = level-sensitive IRR, 0 = rising-edge IRR.
REQ-007 interrupt_mask  input  8  1 = IR line masked.
REQ-008 rotate_mode  input  1  0 = fixed priority (IR0 highest), 1 = rotating priority.
REQ-009 inta_n  input  1  active-low acknowledge, sampled on clk.
REQ-010 eoi_valid  input  1  single-cycle end-of-interrupt command strobe.
REQ-011 eoi_specific  input  1  1 = specific EOI, 0 = non-specific EOI.
REQ-012 eoi_level  input  3  IR level cleared by a specific EOI.
REQ-013 vector_base  input  5  vector bits [7:3].
REQ-014 int_out  output  1  interrupt request to the CPU.
REQ-015 data_out  output  8  vector byte; data_out_valid  output  1  vector qualifier.
REQ-016 interrupt_request_register, in_service_register  output  8 each  live IRR/ISR.

Function
REQ-017 IRR: in level mode bit i SHALL equal ir[i] each cycle; in edge mode bit i SHALL set on a 0->1 transition of ir[i] and clear only on acknowledge of level i.
REQ-018 Priority: a 3-bit lowest_priority pointer SHALL define order, highest = lowest_priority+1 mod 8, wrapping 7->0; fixed mode SHALL force the pointer to 7.
REQ-019 Candidate = highest-priority bit of IRR & ~interrupt_mask; it SHALL be eligible only if strictly higher in priority than the highest ISR bit (fully nested); an empty ISR admits any candidate.
REQ-020 FSM states: IDLE, PEND, ACK1, ACK2; an inta falling edge SHALL be detected as inta_n=0 with previously registered inta_n=1.
REQ-021 IDLE->PEND when an eligible candidate exists; int_out SHALL be high in PEND, registered, one cycle after the request becomes eligible.
REQ-022 PEND->IDLE, deasserting int_out, if the candidate vanishes before the first inta edge.
REQ-023 First inta edge (PEND->ACK1): the winning level SHALL be latched, its ISR bit set, and its IRR bit cleared in edge mode; int_out SHALL drop the same edge.
REQ-024 First inta edge with no eligible candidate, including from IDLE: level 7 SHALL be latched as spurious; ISR SHALL NOT change.
REQ-025 Second inta edge (ACK1->ACK2): data_out = {vector_base, latched level}, and data_out_valid SHALL be high from that cycle while inta_n stays low.
REQ-026 inta_n rising in ACK2: data_out_valid SHALL go low, data_out SHALL go to 0, and the FSM SHALL return to IDLE.
REQ-027 EOI: non-specific SHALL clear the highest-priority set ISR bit; specific SHALL clear ISR[eoi_level]; with rotate_mode=1 the pointer SHALL become the cleared level; an EOI with no target bit set SHALL have no effect.
REQ-028 EOI coincident with a first inta edge: the EOI SHALL apply first, and eligibility SHALL then be re-evaluated on the updated ISR in the same cycle.

Reset
REQ-029 rst_n low SHALL force immediately, including mid-acknowledge: FSM=IDLE, IRR=0, ISR=0, edge history=0, lowest_priority=7, int_out=0, data_out=0, data_out_valid=0, latched level=0, and registered inta_n=1.

Configuration
REQ-030 With AUTO_EOI_EN defined: input auto_eoi (1 bit) SHALL exist; when it is 1, the inta_n rising edge leaving ACK2 SHALL clear the latched ISR bit (never for spurious) and rotate per REQ-027.
REQ-031 Without AUTO_EOI_EN: the auto_eoi port SHALL be absent and ISR SHALL clear only through the EOI command.

Verification
REQ-032 Fixed mode, edge, mask=0, vector_base=5'h08, ir=8'h14 -> int_out=1; two inta pulses -> data_out=8'h42, ISR=8'h04, IRR=8'h10.
REQ-033 Then ir[0] rises while ISR=8'h04 -> int_out=1 (nesting); ir[5] alone with ISR=8'h04 -> int_out stays 0.
REQ-034 Rotating mode, non-specific EOI clearing IR3 -> pointer=3; then IRR=8'h11 -> level 4 acknowledged first, vector low bits 3'd4.
REQ-035 Request dropped in level mode before the first inta edge -> int_out falls; inta cycle anyway -> vector low bits 3'd7, ISR unchanged.
REQ-036 rst_n low during ACK2 -> all outputs 0 the same cycle; FSM=IDLE after release.
REQ-037 With AUTO_EOI_EN and auto_eoi=1, acknowledge IR2 -> ISR=8'h00 after inta_n rises; without the macro, ISR=8'h04 until an EOI command.
